// File: rtl/mb_pkg.sv
// mb_pkg: shared types for the MBOX memory buffer (MB).
//   mb_src_t      - MB_IN_SEL load-source encoding (unlisted codes load zero)
//   mb_fill_t     - MB_DATA_SOURCE fill pattern for NXM/magic loads
//   mb_drain_st_t - drain state machine encoding
package mb_pkg;

  typedef enum logic [2:0] {
    MB_SRC_CSH = 3'd0,
    MB_SRC_AR  = 3'd2,
    MB_SRC_CHB = 3'd3,
    MB_SRC_MEM = 3'd4,
    MB_SRC_CCW = 3'd6
  } mb_src_t;

  typedef enum logic [1:0] {
    MB_FILL_ZERO   = 2'd0,
    MB_FILL_ONES   = 2'd1,
    MB_FILL_BADPAR = 2'd2,
    MB_FILL_KEEP   = 2'd3
  } mb_fill_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2,
    ST_DONE    = 2'd3
  } mb_drain_st_t;

endpackage

// File: rtl/mb_next_valid.sv
// mb_next_valid: combinational circular search over the MB valid flags.
// Returns the first index at or after 'start' (modulo WORDS) whose valid
// flag is set, plus a flag saying whether any word is valid at all.
// When nothing is valid, idx simply echoes start.
// Ports:
//   start [AW]      - first index to consider
//   valid [WORDS]   - per-word valid flags, index 0 leftmost
//   idx   [AW]      - first valid index found
//   any             - at least one flag set
module mb_next_valid #(
  parameter int WORDS = 4,
  localparam int AW = $clog2(WORDS)
) (
  input  logic [AW-1:0]    start,
  input  logic [0:WORDS-1] valid,
  output logic [AW-1:0]    idx,
  output logic             any
);

  // Scan from the farthest candidate back to start so the nearest hit is
  // the last one written. Index arithmetic wraps because WORDS is 2**AW.
  always_comb begin
    idx = start;
    any = |valid;
    for (int k = WORDS - 1; k >= 0; k--) begin
      if (valid[start + AW'(k)]) begin
        idx = start + AW'(k);
      end
    end
  end

endmodule

// File: rtl/mb_buffer.sv
// mb_buffer: four-word, 36-bit MBOX memory buffer with stored odd parity.
// Loads one word per MB_LOAD strobe from the MB_IN_SEL source, performs
// NXM/magic fills, drains valid words to memory and reports MB parity.
// Words are numbered PDP-10 style: bit 0 is the MSB.
//
// Optional feature: define MB_PAR_CHECK_EN to generate the sticky
// MB_PAR_ERR flag; otherwise MB_PAR_ERR is tied low.
//
// Ports:
//   clk, RESET            - clock, synchronous active-high reset
//   MB_IN_SEL, MB_SEL, MB_LOAD, *_D, *_P - normal load path
//   LOAD_MB_MAGIC, MB_DATA_SOURCE, MB_WD_SEL - magic fill path
//   WR_START, WR_FIRST, MEM_ACKN - drain control
//   MEM_DO, MEM_PO, MEM_WD, MEM_WR_VALID, WR_DONE - drain outputs
//   MB_VALID, MB_REQ_HOLD, MB_PAR_ODD, MB_00to17_PAR, MB_18to35_PAR,
//   MB_PAR_ERR            - status
//   dbg_state             - drain state machine state
//
// Drain handshake: while MEM_WR_VALID is high, MEM_DO/MEM_PO/MEM_WD hold
// the presented word steady; the word is consumed on the cycle MEM_ACKN
// is sampled high with MEM_WR_VALID high. MEM_ACKN is ignored otherwise.
module mb_buffer
  import mb_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int WIDTH = 36,
  localparam int AW = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic [2:0]         MB_IN_SEL,
  input  logic [AW-1:0]      MB_SEL,
  input  logic               MB_LOAD,
  input  logic [0:WIDTH-1]   CSH_D,
  input  logic [0:WIDTH-1]   AR_D,
  input  logic [0:WIDTH-1]   CHB_D,
  input  logic [0:WIDTH-1]   MEM_D,
  input  logic [0:WIDTH-1]   CCW_D,
  input  logic               CSH_P,
  input  logic               AR_P,
  input  logic               CHB_P,
  input  logic               MEM_P,
  input  logic               CCW_P,
  input  logic               LOAD_MB_MAGIC,
  input  logic [1:0]         MB_DATA_SOURCE,
  input  logic [AW-1:0]      MB_WD_SEL,
  input  logic               WR_START,
  input  logic [AW-1:0]      WR_FIRST,
  input  logic               MEM_ACKN,
  output logic [0:WIDTH-1]   MEM_DO,
  output logic               MEM_PO,
  output logic [AW-1:0]      MEM_WD,
  output logic               MEM_WR_VALID,
  output logic               WR_DONE,
  output logic [0:WORDS-1]   MB_VALID,
  output logic               MB_REQ_HOLD,
  output logic               MB_PAR_ODD,
  output logic               MB_00to17_PAR,
  output logic               MB_18to35_PAR,
  output logic               MB_PAR_ERR,
  output mb_drain_st_t       dbg_state
);

  // Storage and its next-state copies.
  logic [0:WIDTH-1] mem_d [WORDS];
  logic [0:WIDTH-1] d_n   [WORDS];
  logic [0:WORDS-1] mem_p, p_n;
  logic [0:WORDS-1] valid_q, v_n;

  mb_drain_st_t     state_q, state_n;
  logic [AW-1:0]    ptr_q, ptr_n;
  logic [0:WIDTH-1] mem_do_q;
  logic             mem_po_q;

  logic [0:WIDTH-1] src_d;
  logic             src_p;
  logic             acked;
  logic             magic_same;

  logic [AW-1:0]    srch_start;
  logic [0:WORDS-1] srch_vec;
  logic [AW-1:0]    nv_idx;
  logic             nv_any;

  logic [0:WIDTH-1] sel_d;

  assign acked = (state_q == ST_PRESENT) && MEM_ACKN;
  // A magic load to the word a normal load also targets overrides it.
  assign magic_same = LOAD_MB_MAGIC && (MB_WD_SEL == MB_SEL);

  // Load source mux; unused select codes load zero with good odd parity.
  always_comb begin
    src_d = '0;
    src_p = 1'b1;
    case (MB_IN_SEL)
      MB_SRC_CSH: begin src_d = CSH_D; src_p = CSH_P; end
      MB_SRC_AR:  begin src_d = AR_D;  src_p = AR_P;  end
      MB_SRC_CHB: begin src_d = CHB_D; src_p = CHB_P; end
      MB_SRC_MEM: begin src_d = MEM_D; src_p = MEM_P; end
      MB_SRC_CCW: begin src_d = CCW_D; src_p = CCW_P; end
      default:    ;
    endcase
  end

  // Next storage contents. Order matters: the ack clears the presented
  // word's valid first, so a load to that same word re-validates it.
  always_comb begin
    d_n = mem_d;
    p_n = mem_p;
    v_n = valid_q;
    if (acked) begin
      v_n[ptr_q] = 1'b0;
    end
    if (MB_LOAD && !magic_same) begin
      d_n[MB_SEL] = src_d;
      p_n[MB_SEL] = src_p;
      v_n[MB_SEL] = 1'b1;
    end
    if (LOAD_MB_MAGIC) begin
      case (MB_DATA_SOURCE)
        MB_FILL_ZERO: begin
          d_n[MB_WD_SEL] = '0;
          p_n[MB_WD_SEL] = 1'b1;
          v_n[MB_WD_SEL] = 1'b1;
        end
        MB_FILL_ONES: begin
          d_n[MB_WD_SEL] = '1;
          p_n[MB_WD_SEL] = 1'b1;
          v_n[MB_WD_SEL] = 1'b1;
        end
        MB_FILL_BADPAR: begin
          p_n[MB_WD_SEL] = ~mem_p[MB_WD_SEL];
          v_n[MB_WD_SEL] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Search setup: drain start scans from WR_FIRST; an ack scans from the
  // word after the current one over the post-ack flags (so a reloaded
  // current word comes last, after wrap-around); ACK re-confirms ptr.
  always_comb begin
    srch_start = ptr_q;
    srch_vec   = valid_q;
    case (state_q)
      ST_IDLE:    srch_start = WR_FIRST;
      ST_PRESENT: begin
        srch_start = ptr_q + AW'(1);
        srch_vec   = v_n;
      end
      default:    ;
    endcase
  end

  mb_next_valid #(.WORDS(WORDS)) u_next_valid (
    .start (srch_start),
    .valid (srch_vec),
    .idx   (nv_idx),
    .any   (nv_any)
  );

  // Drain state machine, next-state logic.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (WR_START) begin
          if (nv_any) begin
            state_n = ST_PRESENT;
            ptr_n   = nv_idx;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_PRESENT: begin
        if (MEM_ACKN) begin
          state_n = ST_ACK;
          if (nv_any) begin
            ptr_n = nv_idx;
          end
        end
      end
      ST_ACK: begin
        if (nv_any) begin
          state_n = ST_PRESENT;
          ptr_n   = nv_idx;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The memory output register is loaded from the next pointer and the
  // next storage image, so it always shows word[ptr] including loads.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_d[i] <= '0;
      end
      mem_p    <= '1;
      valid_q  <= '0;
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      mem_do_q <= '0;
      mem_po_q <= 1'b1;
    end else begin
      mem_d    <= d_n;
      mem_p    <= p_n;
      valid_q  <= v_n;
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      mem_do_q <= d_n[ptr_n];
      mem_po_q <= p_n[ptr_n];
    end
  end

`ifdef MB_PAR_CHECK_EN
  logic par_err_q;
  // Sticky: a presented word with even total parity at ack time.
  always_ff @(posedge clk) begin
    if (RESET) begin
      par_err_q <= 1'b0;
    end else if (acked && !(^{mem_do_q, mem_po_q})) begin
      par_err_q <= 1'b1;
    end
  end
  assign MB_PAR_ERR = par_err_q;
`else
  assign MB_PAR_ERR = 1'b0;
`endif

  assign sel_d         = mem_d[MB_SEL];
  assign MB_PAR_ODD    = ^{sel_d, mem_p[MB_SEL]};
  assign MB_00to17_PAR = ^sel_d[0:WIDTH/2-1];
  assign MB_18to35_PAR = ^sel_d[WIDTH/2:WIDTH-1];

  assign MEM_DO       = mem_do_q;
  assign MEM_PO       = mem_po_q;
  assign MEM_WD       = ptr_q;
  assign MEM_WR_VALID = (state_q == ST_PRESENT);
  assign WR_DONE      = (state_q == ST_DONE);
  assign MB_REQ_HOLD  = (state_q != ST_IDLE);
  assign MB_VALID     = valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mb_buffer.sv
// tb_mb_buffer: directed bench for mb_buffer with a behavioural model of
// the buffer contents and drain sequence, compared every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_mb_buffer;
  import mb_pkg::*;

`ifdef MB_PAR_CHECK_EN
  localparam bit PAR_CHECK_ON = 1'b1;
`else
  localparam bit PAR_CHECK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  logic [2:0]  MB_IN_SEL;
  logic [1:0]  MB_SEL;
  logic        MB_LOAD;
  logic [0:35] CSH_D, AR_D, CHB_D, MEM_D, CCW_D;
  logic        CSH_P, AR_P, CHB_P, MEM_P, CCW_P;
  logic        LOAD_MB_MAGIC;
  logic [1:0]  MB_DATA_SOURCE;
  logic [1:0]  MB_WD_SEL;
  logic        WR_START;
  logic [1:0]  WR_FIRST;
  logic        MEM_ACKN;
  logic [0:35] MEM_DO;
  logic        MEM_PO;
  logic [1:0]  MEM_WD;
  logic        MEM_WR_VALID, WR_DONE;
  logic [0:3]  MB_VALID;
  logic        MB_REQ_HOLD, MB_PAR_ODD, MB_00to17_PAR, MB_18to35_PAR, MB_PAR_ERR;
  mb_drain_st_t dbg_state;

  mb_buffer dut (
    .clk(clk), .RESET(RESET),
    .MB_IN_SEL(MB_IN_SEL), .MB_SEL(MB_SEL), .MB_LOAD(MB_LOAD),
    .CSH_D(CSH_D), .AR_D(AR_D), .CHB_D(CHB_D), .MEM_D(MEM_D), .CCW_D(CCW_D),
    .CSH_P(CSH_P), .AR_P(AR_P), .CHB_P(CHB_P), .MEM_P(MEM_P), .CCW_P(CCW_P),
    .LOAD_MB_MAGIC(LOAD_MB_MAGIC), .MB_DATA_SOURCE(MB_DATA_SOURCE),
    .MB_WD_SEL(MB_WD_SEL),
    .WR_START(WR_START), .WR_FIRST(WR_FIRST), .MEM_ACKN(MEM_ACKN),
    .MEM_DO(MEM_DO), .MEM_PO(MEM_PO), .MEM_WD(MEM_WD),
    .MEM_WR_VALID(MEM_WR_VALID), .WR_DONE(WR_DONE),
    .MB_VALID(MB_VALID), .MB_REQ_HOLD(MB_REQ_HOLD), .MB_PAR_ODD(MB_PAR_ODD),
    .MB_00to17_PAR(MB_00to17_PAR), .MB_18to35_PAR(MB_18to35_PAR),
    .MB_PAR_ERR(MB_PAR_ERR), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [0:35] m_d [4];
  logic [0:3]  m_p;
  logic [0:3]  m_v;
  bit          m_busy, m_presenting, m_gap, m_done, m_err;
  int          m_ptr;

  function automatic int nv(input int start, input logic [0:3] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return start % 4;
  endfunction

  function automatic logic [36:0] src_word();
    case (MB_IN_SEL)
      3'd0: return {CSH_D, CSH_P};
      3'd2: return {AR_D, AR_P};
      3'd3: return {CHB_D, CHB_P};
      3'd4: return {MEM_D, MEM_P};
      3'd6: return {CCW_D, CCW_P};
      default: return {36'd0, 1'b1};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [0:3]  old_v;
    logic [36:0] r;
    bit          acked;
    if (RESET) begin
      for (int i = 0; i < 4; i++) m_d[i] = '0;
      m_p = '1; m_v = '0;
      m_busy = 0; m_presenting = 0; m_gap = 0; m_done = 0; m_err = 0; m_ptr = 0;
    end else begin
      old_v = m_v;
      acked = m_presenting && MEM_ACKN;
      if (acked) begin
        if (PAR_CHECK_ON && ($countones(m_d[m_ptr]) + int'(m_p[m_ptr])) % 2 == 0) m_err = 1;
        m_v[m_ptr] = 1'b0;
      end
      if (MB_LOAD && !(LOAD_MB_MAGIC && MB_WD_SEL == MB_SEL)) begin
        r = src_word();
        m_d[MB_SEL] = r[36:1];
        m_p[MB_SEL] = r[0];
        m_v[MB_SEL] = 1'b1;
      end
      if (LOAD_MB_MAGIC) begin
        case (MB_DATA_SOURCE)
          2'd0: begin m_d[MB_WD_SEL] = '0; m_p[MB_WD_SEL] = 1'b1; m_v[MB_WD_SEL] = 1'b1; end
          2'd1: begin m_d[MB_WD_SEL] = '1; m_p[MB_WD_SEL] = 1'b1; m_v[MB_WD_SEL] = 1'b1; end
          2'd2: begin m_p[MB_WD_SEL] = ~m_p[MB_WD_SEL]; m_v[MB_WD_SEL] = 1'b1; end
          default: ;
        endcase
      end
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (WR_START) begin
          m_busy = 1;
          if (old_v != 0) begin m_presenting = 1; m_ptr = nv(int'(WR_FIRST), old_v); end
          else m_done = 1;
        end
      end else if (m_presenting) begin
        if (acked) begin
          m_presenting = 0; m_gap = 1;
          if (m_v != 0) m_ptr = nv(m_ptr + 1, m_v);
        end
      end else if (m_gap) begin
        m_gap = 0;
        if (old_v != 0) begin m_presenting = 1; m_ptr = nv(m_ptr, old_v); end
        else m_done = 1;
      end
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mb_valid", MB_VALID, m_v);
      check("mem_do", MEM_DO, m_d[m_ptr]);
      check("mem_po", MEM_PO, m_p[m_ptr]);
      check("mem_wd", MEM_WD, 64'(m_ptr));
      check("mem_wr_valid", MEM_WR_VALID, m_presenting);
      check("wr_done", WR_DONE, m_done);
      check("req_hold", MB_REQ_HOLD, m_busy);
      check("par_err", MB_PAR_ERR, m_err);
      check("par_odd", MB_PAR_ODD, ($countones(m_d[MB_SEL]) + int'(m_p[MB_SEL])) % 2);
      check("par_hi", MB_00to17_PAR, $countones(m_d[MB_SEL] >> 18) % 2);
      check("par_lo", MB_18to35_PAR, $countones(m_d[MB_SEL] & 36'h3_FFFF) % 2);
    end
  end

  // ---------------- driver tasks ----------------
  bit          rec_v    [16];
  bit          rec_done [16];
  int          rec_wd   [16];
  logic [0:35] rec_do   [16];
  logic        rec_po   [16];

  task automatic cyc_go();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [2:0] src, input logic [0:35] d);
    MB_LOAD = 1'b1; MB_SEL = sel; MB_IN_SEL = src;
    case (src)
      3'd0: begin CSH_D = d; CSH_P = ~^d; end
      3'd2: begin AR_D  = d; AR_P  = ~^d; end
      3'd3: begin CHB_D = d; CHB_P = ~^d; end
      3'd4: begin MEM_D = d; MEM_P = ~^d; end
      3'd6: begin CCW_D = d; CCW_P = ~^d; end
      default: ;
    endcase
    cyc_go();
    MB_LOAD = 1'b0;
  endtask

  task automatic magic(input logic [1:0] wd, input logic [1:0] fill);
    LOAD_MB_MAGIC = 1'b1; MB_WD_SEL = wd; MB_DATA_SOURCE = fill;
    cyc_go();
    LOAD_MB_MAGIC = 1'b0;
  endtask

  // WR_START in cycle 0 with ack held high; cycle k outputs recorded at
  // its falling edge. Optionally reloads word ld_sel from MEM in cycle ld_k.
  task automatic drain(input logic [1:0] first, input int n, input int ld_k,
                       input logic [1:0] ld_sel, input logic [0:35] ld_d);
    for (int k = 0; k < 16; k++) begin rec_v[k] = 0; rec_done[k] = 0; rec_wd[k] = -1; end
    WR_START = 1'b1; WR_FIRST = first; MEM_ACKN = 1'b1;
    for (int k = 1; k <= n; k++) begin
      cyc_go();
      WR_START = 1'b0;
      MB_LOAD  = 1'b0;
      if (k == ld_k) begin
        MB_LOAD = 1'b1; MB_SEL = ld_sel; MB_IN_SEL = 3'd4; MEM_D = ld_d; MEM_P = ~^ld_d;
      end
      @(negedge clk);
      rec_v[k] = MEM_WR_VALID; rec_done[k] = WR_DONE; rec_wd[k] = int'(MEM_WD);
      rec_do[k] = MEM_DO; rec_po[k] = MEM_PO;
    end
    MEM_ACKN = 1'b0;
    MB_LOAD  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RESET = 1'b1;
    MB_IN_SEL = 3'd0; MB_SEL = 2'd0; MB_LOAD = 1'b0;
    CSH_D = 36'({$urandom(), $urandom()}); AR_D = 36'({$urandom(), $urandom()});
    CHB_D = 36'({$urandom(), $urandom()}); MEM_D = 36'({$urandom(), $urandom()});
    CCW_D = 36'({$urandom(), $urandom()});
    CSH_P = 1'b0; AR_P = 1'b1; CHB_P = 1'b0; MEM_P = 1'b1; CCW_P = 1'b0;
    LOAD_MB_MAGIC = 1'b0; MB_DATA_SOURCE = 2'd3; MB_WD_SEL = 2'd0;
    WR_START = 1'b0; WR_FIRST = 2'd0; MEM_ACKN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_mem_do", MEM_DO, 36'd0);
    check("rst_mem_po", MEM_PO, 1'b1);
    check("rst_mem_wd", MEM_WD, 2'd0);
    check("rst_valid", MB_VALID, 4'b0000);
    check("rst_hold", MB_REQ_HOLD, 1'b0);
    check("rst_wr_valid", MEM_WR_VALID, 1'b0);
    check("rst_par_err", MB_PAR_ERR, 1'b0);

    // AR load into word 2
    load(2'd2, 3'd2, 36'o123456_701234);
    @(negedge clk);
    check("t1_valid", MB_VALID, 4'b0010);
    check("t1_par_odd", MB_PAR_ODD, 1'b1);
    check("t1_par_hi", MB_00to17_PAR, 1'b1);
    check("t1_par_lo", MB_18to35_PAR, 1'b0);

    // Four-word drain from word 2 (word 1 uses a zero select)
    load(2'd0, 3'd4, 36'o111111_222222);
    load(2'd1, 3'd5, 36'o777777_777777);
    load(2'd3, 3'd6, 36'o000123_000456);
    drain(2'd2, 11, -1, 2'd0, 36'd0);
    check("t2_pres1", rec_v[1], 1'b1);
    check("t2_gap2", rec_v[2], 1'b0);
    check("t2_wd1", rec_wd[1], 2);
    check("t2_wd3", rec_wd[3], 3);
    check("t2_wd5", rec_wd[5], 0);
    check("t2_wd7", rec_wd[7], 1);
    check("t2_zero_word", rec_do[7], 36'd0);
    check("t2_done8", rec_done[8], 1'b0);
    check("t2_done9", rec_done[9], 1'b1);
    check("t2_valid", MB_VALID, 4'b0000);
    check("t2_par_err", MB_PAR_ERR, 1'b0);

    // Single valid word, drain started past it
    load(2'd1, 3'd3, 36'o543210_012345);
    drain(2'd3, 5, -1, 2'd0, 36'd0);
    check("t3_pres", rec_v[1], 1'b1);
    check("t3_wd", rec_wd[1], 1);
    check("t3_no_second", rec_v[3], 1'b0);
    check("t3_done", rec_done[3], 1'b1);

    // Drain with nothing valid
    drain(2'd0, 3, -1, 2'd0, 36'd0);
    check("t3e_done1", rec_done[1], 1'b1);
    check("t3e_nopres", rec_v[1], 1'b0);
    check("t3e_done2", rec_done[2], 1'b0);

    // Magic bad-parity fill on word 0
    load(2'd0, 3'd0, 36'o000000_000007);
    magic(2'd0, 2'd2);
    MB_SEL = 2'd0;
    @(negedge clk);
    check("t4_par_odd", MB_PAR_ODD, 1'b0);
    drain(2'd0, 4, -1, 2'd0, 36'd0);
    check("t4_mem_po", rec_po[1], 1'b1);
    check("t4_mem_do", rec_do[1], 36'o000000_000007);
    check("t4_par_err", MB_PAR_ERR, PAR_CHECK_ON);

    // Same-word conflict (magic ones wins), then different-word conflict
    MB_LOAD = 1'b1; MB_SEL = 2'd3; MB_IN_SEL = 3'd2; AR_D = 36'd5; AR_P = 1'b1;
    LOAD_MB_MAGIC = 1'b1; MB_WD_SEL = 2'd3; MB_DATA_SOURCE = 2'd1;
    cyc_go();
    MB_SEL = 2'd1; MB_IN_SEL = 3'd6; CCW_D = 36'o707070_070707; CCW_P = ~^CCW_D;
    MB_WD_SEL = 2'd2; MB_DATA_SOURCE = 2'd0;
    cyc_go();
    MB_LOAD = 1'b0; LOAD_MB_MAGIC = 1'b0; MB_SEL = 2'd3;
    @(negedge clk);
    check("t5_valid", MB_VALID, 4'b0111);
    check("t5_par_odd", MB_PAR_ODD, 1'b1);
    check("t5_par_hi", MB_00to17_PAR, 1'b0);
    check("t5_par_lo", MB_18to35_PAR, 1'b0);
    drain(2'd3, 9, -1, 2'd0, 36'd0);
    check("t5_ones", rec_do[1], 36'hF_FFFF_FFFF);
    check("t5_wd1", rec_wd[1], 3);
    check("t5_wd3", rec_wd[3], 1);
    check("t5_do3", rec_do[3], 36'o707070_070707);
    check("t5_wd5", rec_wd[5], 2);
    check("t5_done", rec_done[7], 1'b1);

    // Reload of the presented word during the drain
    load(2'd0, 3'd4, 36'o000001_000001);
    load(2'd1, 3'd2, 36'o000002_000002);
    drain(2'd0, 9, 1, 2'd0, 36'o456456_456456);
    check("t7_wd1", rec_wd[1], 0);
    check("t7_wd3", rec_wd[3], 1);
    check("t7_wd5", rec_wd[5], 0);
    check("t7_do5", rec_do[5], 36'o456456_456456);
    check("t7_done", rec_done[7], 1'b1);

    // Reset in PRESENT
    load(2'd2, 3'd2, 36'o135246_753124);
    WR_START = 1'b1; WR_FIRST = 2'd0; MEM_ACKN = 1'b0;
    cyc_go();
    WR_START = 1'b0;
    @(negedge clk);
    check("t6_present", MEM_WR_VALID, 1'b1);
    check("t6_wd", MEM_WD, 2'd2);
    RESET = 1'b1;
    cyc_go();
    RESET = 1'b0;
    @(negedge clk);
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_valid", MB_VALID, 4'b0000);
    check("t6_wr_valid", MEM_WR_VALID, 1'b0);
    check("t6_wr_done", WR_DONE, 1'b0);
    check("t6_hold", MB_REQ_HOLD, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc_go();
      @(negedge clk);
      check("t6_no_done", WR_DONE, 1'b0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
